// File: rtl/itp_play_ctrl.sv
// itp_play_ctrl: slow-motion playback sequencer.
// Fetches consecutive signed samples from the memory reader and emits one
// output per accepted DAC tick, N = i_speed+1 outputs per source pair.
// Build option: define ITP_LINEAR_EN for linear interpolation between the
// pair (sequential floor divide-by-N); without it the engine does a
// zero-order hold (every output of a segment equals the first sample).
module itp_play_ctrl #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_pause,
    input  logic [2:0]        i_speed,
    input  logic [ADDR_W-1:0] i_end_addr,
    output logic              o_req,
    output logic [ADDR_W-1:0] o_addr,
    input  logic              i_ack,
    input  logic [DATA_W-1:0] i_sample,
    input  logic              i_dac_tick,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_underrun
);

    // Weighted sum prev*(N-k) + next*k needs DATA_W+3 magnitude bits plus sign.
    localparam int ACC_W = DATA_W + 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH0,
        S_FETCH,
        S_CALC,
        S_READY,
        S_LAST
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    // One extra address bit so "fetched past end_addr" is still detected
    // when end_addr is the top of the address space.
    logic [ADDR_W:0]   r_addr;
    logic [ADDR_W-1:0] r_end;
    logic [3:0]        r_n;        // outputs per segment, 1..8
    logic [3:0]        r_k;        // output index inside the segment
    logic [DATA_W-1:0] r_prev;
    logic [DATA_W-1:0] r_next;
    logic [DATA_W-1:0] r_pending;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_done;
    logic              r_underrun;

    logic              w_tick_acc;
    logic              w_tick_miss;
    logic              w_seg_end;
    logic              w_past_end;
    logic              w_calc_done;
    logic [3:0]        w_n_new;
    logic [DATA_W-1:0] w_calc_result;

    assign w_n_new    = {1'b0, i_speed} + 4'd1;
    assign w_seg_end  = (r_k + 4'd1) == r_n;
    assign w_past_end = r_addr > {1'b0, r_end};

    assign o_addr     = r_addr[ADDR_W-1:0];
    assign o_data     = r_data;
    assign o_valid    = r_valid;
    assign o_done     = r_done;
    assign o_underrun = r_underrun;

`ifdef ITP_LINEAR_EN
    // Divider runs: 1 load cycle, ACC_W shift/subtract steps, 1 result cycle.
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_W + 1);

    logic [CNT_W-1:0]        r_cnt;
    logic [ACC_W-1:0]        r_quo;
    logic [3:0]              r_rem;
    logic                    r_neg;

    logic [3:0]              w_nmk;
    logic signed [ACC_W-1:0] w_prev_x;
    logic signed [ACC_W-1:0] w_next_x;
    logic signed [ACC_W-1:0] w_nmk_x;
    logic signed [ACC_W-1:0] w_k_x;
    logic signed [ACC_W-1:0] w_sum;
    logic [ACC_W-1:0]        w_mag;
    logic [4:0]              w_trial;
    logic                    w_qbit;
    logic [3:0]              w_rem_next;
    logic [ACC_W-1:0]        w_quo_adj;

    assign w_nmk    = r_n - r_k;
    assign w_prev_x = {{(ACC_W-DATA_W){r_prev[DATA_W-1]}}, r_prev};
    assign w_next_x = {{(ACC_W-DATA_W){r_next[DATA_W-1]}}, r_next};
    assign w_nmk_x  = {{(ACC_W-4){1'b0}}, w_nmk};
    assign w_k_x    = {{(ACC_W-4){1'b0}}, r_k};
    assign w_sum    = (w_prev_x * w_nmk_x) + (w_next_x * w_k_x);
    assign w_mag    = w_sum[ACC_W-1] ? -w_sum : w_sum;

    // Restoring division of |W| by N; remainder stays below N (<= 8).
    assign w_trial    = {r_rem, r_quo[ACC_W-1]};
    assign w_qbit     = w_trial >= {1'b0, r_n};
    assign w_rem_next = w_qbit ? 4'(w_trial - {1'b0, r_n}) : w_trial[3:0];

    // Floor for negative sums: -(|W| div N) - 1 when the division is inexact.
    assign w_quo_adj     = r_quo + ACC_W'(r_rem != 4'd0);
    assign w_calc_result = r_neg ? DATA_W'(~w_quo_adj + 1'b1) : DATA_W'(r_quo);
    assign w_calc_done   = (r_cnt == CNT_LAST);

    // Sequential signed floor divide, restarted on every CALC entry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_quo <= '0;
            r_rem <= '0;
            r_neg <= 1'b0;
        end else if (i_stop || r_state != S_CALC) begin
            r_cnt <= '0;
        end else if (r_cnt == '0) begin
            r_quo <= w_mag;
            r_rem <= 4'd0;
            r_neg <= w_sum[ACC_W-1];
            r_cnt <= CNT_W'(1);
        end else if (!w_calc_done) begin
            r_quo <= {r_quo[ACC_W-2:0], w_qbit};
            r_rem <= w_rem_next;
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end
`else
    // Zero-order hold: every output of a segment is the segment's first sample.
    assign w_calc_done   = 1'b1;
    assign w_calc_result = r_prev;
`endif

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode, fetch request and tick classification.
    always_comb begin
        w_state_next = r_state;
        w_tick_acc   = 1'b0;
        w_tick_miss  = 1'b0;
        o_req        = 1'b0;
        o_busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_FETCH0;
                end
            end
            S_FETCH0: begin
                o_req       = 1'b1;
                w_tick_miss = i_dac_tick && !i_pause;
                if (i_ack) begin
                    w_state_next = (r_end == '0) ? S_CALC : S_FETCH;
                end
            end
            S_FETCH: begin
                o_req       = 1'b1;
                w_tick_miss = i_dac_tick && !i_pause;
                if (i_ack) begin
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                w_tick_miss = i_dac_tick && !i_pause;
                if (w_calc_done) begin
                    w_state_next = S_READY;
                end
            end
            S_READY: begin
                w_tick_acc = i_dac_tick && !i_pause;
                if (w_tick_acc) begin
                    if (w_seg_end) begin
                        w_state_next = w_past_end ? S_LAST : S_FETCH;
                    end else begin
                        w_state_next = S_CALC;
                    end
                end
            end
            S_LAST: begin
                w_tick_acc = i_dac_tick && !i_pause;
                if (w_tick_acc) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        // Stop wins over any tick or ack in the same cycle.
        if (i_stop) begin
            w_state_next = S_IDLE;
            w_tick_acc   = 1'b0;
            w_tick_miss  = 1'b0;
        end
    end

    // Sample pipeline, segment counters and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr     <= '0;
            r_end      <= '0;
            r_n        <= 4'd0;
            r_k        <= 4'd0;
            r_prev     <= '0;
            r_next     <= '0;
            r_pending  <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            if (i_stop) begin
                r_data <= '0;
                r_addr <= '0;
                r_k    <= 4'd0;
            end else begin
                if (w_tick_miss) begin
                    r_underrun <= 1'b1;
                end
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_end      <= i_end_addr;
                            r_addr     <= '0;
                            r_k        <= 4'd0;
                            r_underrun <= 1'b0;
                        end
                    end
                    S_FETCH0: begin
                        if (i_ack) begin
                            r_prev <= i_sample;
                            r_addr <= r_addr + 1'b1;
                            // Single-sample playback: flat segment from that sample.
                            if (r_end == '0) begin
                                r_next <= i_sample;
                                r_n    <= w_n_new;
                            end
                        end
                    end
                    S_FETCH: begin
                        if (i_ack) begin
                            r_next <= i_sample;
                            r_addr <= r_addr + 1'b1;
                            // k is 0 here, so the speed code is sampled per segment.
                            r_n    <= w_n_new;
                        end
                    end
                    S_CALC: begin
                        if (w_calc_done) begin
                            r_pending <= w_calc_result;
                        end
                    end
                    S_READY: begin
                        if (w_tick_acc) begin
                            r_data  <= r_pending;
                            r_valid <= 1'b1;
                            if (w_seg_end) begin
                                r_k       <= 4'd0;
                                r_prev    <= r_next;
                                // Used directly by LAST; overwritten by CALC otherwise.
                                r_pending <= r_next;
                            end else begin
                                r_k <= r_k + 4'd1;
                            end
                        end
                    end
                    S_LAST: begin
                        if (w_tick_acc) begin
                            r_data  <= r_pending;
                            r_valid <= 1'b1;
                            r_done  <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
